// File: rtl/mem_pkg.sv
// mem_pkg: shared SDRAM widths and arbiter state encoding
//   SDRAM_AW    SDRAM word-address width
//   SDRAM_DW    SDRAM data width
//   arb_state_t arbiter FSM states
package mem_pkg;
   localparam int SDRAM_AW = 23;
   localparam int SDRAM_DW = 16;
   typedef enum logic [1:0] {IDLE, BUSY, RELEASE} arb_state_t;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin pick of the first requester at or above ptr
//   req      in  per-port request
//   ptr      in  highest-priority port index
//   win      out one-hot winner (all zero when nobody requests)
//   win_idx  out index of the winner
module rr_picker #(
   parameter int NUM_PORTS = 4,
   localparam int PW = $clog2(NUM_PORTS)
) (
   input  logic [NUM_PORTS-1:0] req,
   input  logic [PW-1:0]        ptr,
   output logic [NUM_PORTS-1:0] win,
   output logic [PW-1:0]        win_idx
);
   int   j;
   logic found;
   always_comb begin
      win = '0;
      win_idx = '0;
      found = 1'b0;
      j = 0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         j = int'(ptr) + i;
         j = j >= NUM_PORTS ? j - NUM_PORTS : j;
         if (!found && req[PW'(j)]) begin
            found = 1'b1;
            win[PW'(j)] = 1'b1;
            win_idx = PW'(j);
         end
      end
   end
endmodule

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: round-robin sharing of one SDRAM access port among NUM_PORTS requesters
//   clk, rst               clock, asynchronous active-high reset
//   req/req_rw/req_addr/req_wdata  per-port request, direction (1 = write), address, write data
//   gnt                    one-hot grant held from BUSY entry through RELEASE
//   port_done/port_err     one-cycle completion / abort pulse to the granted port
//   rdata                  read data, valid with port_done
//   timeout_flag           sticky abort indicator
//   SDRAM_*                single SDRAM access interface
module sdram_port_arbiter
   import mem_pkg::*;
#(
   parameter int NUM_PORTS = 4,
   parameter int TIMEOUT   = 255,
   localparam int PW = $clog2(NUM_PORTS)
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [NUM_PORTS-1:0]               req,
   input  logic [NUM_PORTS-1:0]               req_rw,
   input  logic [NUM_PORTS-1:0][SDRAM_AW-1:0] req_addr,
   input  logic [NUM_PORTS-1:0][SDRAM_DW-1:0] req_wdata,
   output logic [NUM_PORTS-1:0]               gnt,
   output logic [NUM_PORTS-1:0]               port_done,
   output logic [NUM_PORTS-1:0]               port_err,
   output logic [SDRAM_DW-1:0]                rdata,
   output logic                               timeout_flag,
   output logic                               SDRAM_as,
   output logic                               SDRAM_rw,
   output logic [SDRAM_AW-1:0]                SDRAM_addr,
   output logic [SDRAM_DW-1:0]                SDRAM_data_write,
   input  logic [SDRAM_DW-1:0]                SDRAM_data_read,
   input  logic                               SDRAM_done
);
   arb_state_t           state;
   logic [PW-1:0]        ptr;
   logic [NUM_PORTS-1:0] win;
   logic [PW-1:0]        win_idx;
   logic [7:0]           cnt;
   logic                 lat_rw;
   logic [SDRAM_AW-1:0]  lat_addr;
   logic [SDRAM_DW-1:0]  lat_wdata;
   logic                 busy_end;

   rr_picker #(.NUM_PORTS(NUM_PORTS)) u_pick (
      .req     (req),
      .ptr     (ptr),
      .win     (win),
      .win_idx (win_idx)
   );

   // strobe drops in the very cycle done is seen so the SDRAM never restarts
   assign SDRAM_as         = state == BUSY && !SDRAM_done;
   assign SDRAM_rw         = lat_rw;
   assign SDRAM_addr       = lat_addr;
   assign SDRAM_data_write = lat_wdata;
   // done wins over a coincident timeout
   assign busy_end         = SDRAM_done || cnt == 8'(TIMEOUT - 1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         ptr          <= '0;
         gnt          <= '0;
         port_done    <= '0;
         port_err     <= '0;
         rdata        <= '0;
         timeout_flag <= 1'b0;
         cnt          <= '0;
         lat_rw       <= 1'b0;
         lat_addr     <= '0;
         lat_wdata    <= '0;
      end else begin
         port_done <= '0;
         port_err  <= '0;
         case (state)
            IDLE: if (|req) begin
               state     <= BUSY;
               gnt       <= win;
               ptr       <= win_idx == PW'(NUM_PORTS - 1) ? '0 : win_idx + 1'b1;
               cnt       <= '0;
               lat_rw    <= req_rw[win_idx];
               lat_addr  <= req_addr[win_idx];
               lat_wdata <= req_wdata[win_idx];
            end
            BUSY: if (busy_end) begin
               state        <= RELEASE;
               port_done    <= gnt;
               port_err     <= SDRAM_done ? '0 : gnt;
               rdata        <= SDRAM_done && !lat_rw ? SDRAM_data_read : '0;
               timeout_flag <= timeout_flag | !SDRAM_done;
            end else begin
               cnt <= cnt + 8'd1;
            end
            RELEASE: if (!SDRAM_done) begin
               state <= IDLE;
               gnt   <= '0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
